// File: rtl/cla_multiword_wrapper.sv
// rtl/cla_multiword_wrapper.sv - byte-addressed multiword adder/subtractor built on a 16-bit CLA slice
//
// Purpose:
//   Operands A and B (WIDTH bits each) are loaded one byte at a time over a
//   simple byte register port. A START command runs the sum one 16-bit slice
//   per clock through a carry-lookahead slice (cla16). The carry between slices
//   is registered. RESULT, FLAGS and STATUS can be read back at any time.
//
// Ports:
//   CLK   in   1  clock; all state updates on the rising edge
//   RST   in   1  synchronous, active-low reset
//   DIN   in   8  write data byte
//   ADDR  in   8  byte register address
//   RDWR  in   1  1 = write DIN to ADDR, 0 = read ADDR
//   DOUT  out  8  registered read data, one-cycle latency, held during writes
//   DONE  out  1  one-cycle pulse while the result is committed
//
// Address map:
//   0x00+i A byte i      0x10+i B byte i      0x20 CTRL {SUB, CIN}
//   0x21   CMD bit0 = START                   0x30+i RESULT byte i
//   0x40   FLAGS {ZERO, OVF, COUT}            0x41 STATUS {DONE_STICKY, BUSY}

module cla_multiword_wrapper #(
   parameter int WIDTH = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] DIN,
   input  logic [7:0] ADDR,
   input  logic       RDWR,
   output logic [7:0] DOUT,
   output logic       DONE
);

   localparam int NS = WIDTH / 16;
   localparam int NB = WIDTH / 8;
   localparam logic [3:0] LAST_SLICE = 4'(NS - 1);
   localparam logic [4:0] NB5 = 5'(NB);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      CMPL = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Programmer-visible registers
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             cin_reg;
   logic             sub_reg;
   logic [WIDTH-1:0] result_reg;
   logic             cout_flag;
   logic             ovf_flag;
   logic             zero_flag;
   logic             busy;
   logic             done_sticky;

   // Working copies taken at START; wb already holds B' (inverted for SUB)
   logic [WIDTH-1:0] wa;
   logic [WIDTH-1:0] wb;
   logic             carry;
   logic [3:0]       slice_cnt;

   logic [15:0]      op_a;
   logic [15:0]      op_b;
   logic [15:0]      slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] result_nxt;

   logic             in_window;
   logic             start_cmd;
   logic             start_acc;
   logic [7:0]       rd_data;

   // Byte index inside a 16-byte window is valid only below NB
   assign in_window = ({1'b0, ADDR[3:0]} < NB5);
   assign start_cmd = RDWR && (ADDR == 8'h21) && DIN[0];

   // FSM next-state and outputs
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      DONE      = 1'b0;
      case (state)
         IDLE: begin
            if (start_cmd) begin
               state_nxt = CALC;
               start_acc = 1'b1;
            end
         end
         CALC: begin
            if (slice_cnt == LAST_SLICE) begin
               state_nxt = CMPL;
            end
         end
         CMPL: begin
            DONE      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Select the operand slice for the current CALC cycle and merge its sum
   always_comb begin
      op_a       = 16'h0000;
      op_b       = 16'h0000;
      result_nxt = result_reg;
      for (int k = 0; k < NS; k++) begin
         if (slice_cnt == 4'(k)) begin
            op_a                  = wa[16*k +: 16];
            op_b                  = wb[16*k +: 16];
            result_nxt[16*k +: 16] = slice_sum;
         end
      end
   end

   cla16 u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Read mux
   always_comb begin
      rd_data = 8'hF0;
      case (ADDR[7:4])
         4'h0: begin
            rd_data = 8'h00;
            for (int i = 0; i < NB; i++) begin
               if (ADDR[3:0] == 4'(i)) begin
                  rd_data = a_reg[8*i +: 8];
               end
            end
         end
         4'h1: begin
            rd_data = 8'h00;
            for (int i = 0; i < NB; i++) begin
               if (ADDR[3:0] == 4'(i)) begin
                  rd_data = b_reg[8*i +: 8];
               end
            end
         end
         4'h2: begin
            if (ADDR[3:0] == 4'h0) begin
               rd_data = {6'b000000, sub_reg, cin_reg};
            end else if (ADDR[3:0] == 4'h1) begin
               rd_data = 8'h00;
            end
         end
         4'h3: begin
            rd_data = 8'h00;
            for (int i = 0; i < NB; i++) begin
               if (ADDR[3:0] == 4'(i)) begin
                  rd_data = result_reg[8*i +: 8];
               end
            end
         end
         4'h4: begin
            if (ADDR[3:0] == 4'h0) begin
               rd_data = {5'b00000, zero_flag, ovf_flag, cout_flag};
            end else if (ADDR[3:0] == 4'h1) begin
               rd_data = {6'b000000, done_sticky, busy};
            end
         end
         default: begin
            rd_data = 8'hF0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         cin_reg     <= 1'b0;
         sub_reg     <= 1'b0;
         result_reg  <= '0;
         cout_flag   <= 1'b0;
         ovf_flag    <= 1'b0;
         zero_flag   <= 1'b0;
         busy        <= 1'b0;
         done_sticky <= 1'b0;
         wa          <= '0;
         wb          <= '0;
         carry       <= 1'b0;
         slice_cnt   <= 4'h0;
         DOUT        <= 8'h00;
      end else begin
         state <= state_nxt;

         if (!RDWR) begin
            DOUT <= rd_data;
         end

         // Operand and control writes are locked out for the whole operation
         if (RDWR && !busy) begin
            for (int i = 0; i < NB; i++) begin
               if (in_window && ADDR[3:0] == 4'(i)) begin
                  if (ADDR[7:4] == 4'h0) begin
                     a_reg[8*i +: 8] <= DIN;
                  end
                  if (ADDR[7:4] == 4'h1) begin
                     b_reg[8*i +: 8] <= DIN;
                  end
               end
            end
            if (ADDR == 8'h20) begin
               cin_reg <= DIN[0];
               sub_reg <= DIN[1];
            end
         end

         if (start_acc) begin
            wa          <= a_reg;
            wb          <= sub_reg ? ~b_reg : b_reg;
            carry       <= sub_reg | cin_reg;
            slice_cnt   <= 4'h0;
            busy        <= 1'b1;
            done_sticky <= 1'b0;
         end

         if (state == CALC) begin
            result_reg <= result_nxt;
            carry      <= slice_cout;
            slice_cnt  <= slice_cnt + 4'h1;
            if (slice_cnt == LAST_SLICE) begin
               cout_flag <= slice_cout;
               ovf_flag  <= (wa[WIDTH-1] == wb[WIDTH-1]) &&
                            (result_nxt[WIDTH-1] != wa[WIDTH-1]);
               zero_flag <= (result_nxt == '0);
            end
         end

         if (state == CMPL) begin
            busy        <= 1'b0;
            done_sticky <= 1'b1;
         end
      end
   end

endmodule

// 16-bit carry-lookahead adder slice.
//   a, b  in   16  addends
//   cin   in    1  carry in
//   sum   out  16  sum
//   cout  out   1  carry out
// Four 4-bit groups each produce group generate/propagate; a second-level
// lookahead derives every group carry-in directly from cin.
module cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [3:0]  gc;

   assign g = a & b;
   assign p = a ^ b;

   genvar j;
   generate
      for (j = 0; j < 4; j++) begin : g_grp
         localparam int B0 = 4 * j;
         assign gg[j] = g[B0+3]
                      | (p[B0+3] & g[B0+2])
                      | (p[B0+3] & p[B0+2] & g[B0+1])
                      | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
         assign gp[j] = &p[B0+3:B0];
         assign c[B0]   = gc[j];
         assign c[B0+1] = g[B0] | (p[B0] & gc[j]);
         assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0])
                        | (p[B0+1] & p[B0] & gc[j]);
         assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1])
                        | (p[B0+2] & p[B0+1] & g[B0])
                        | (p[B0+2] & p[B0+1] & p[B0] & gc[j]);
      end
   endgenerate

   assign gc[0] = cin;
   assign gc[1] = gg[0] | (gp[0] & cin);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & cin);
   assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

   assign sum = p ^ c;

endmodule

// File: tb/tb_cla_multiword_wrapper.sv
// tb/tb_cla_multiword_wrapper.sv - randomized self-checking bench for cla_multiword_wrapper
//
// Purpose: drives the byte register port, compares RESULT/FLAGS/STATUS and
// DONE timing against a plain-arithmetic reference model.
// Ports: none (top-level bench).

module tb_cla_multiword_wrapper;

   localparam int W  = 64;
   localparam int NS = W / 16;
   localparam int NB = W / 8;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic [7:0] addr;
   logic       rdwr;
   logic [7:0] dout;
   logic       done;

   int vectors     = 0;
   int miscompares = 0;
   int done_pulses = 0;

   cla_multiword_wrapper #(.WIDTH(W)) dut (
      .CLK  (clk),
      .RST  (rst),
      .DIN  (din),
      .ADDR (addr),
      .RDWR (rdwr),
      .DOUT (dout),
      .DONE (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_pulses++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: full-width arithmetic with the B inversion/carry rules
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] sum, output logic [7:0] fl);
      logic [W-1:0] bp;
      logic [W:0]   full;
      logic         c0;
      logic         ovf;
      bp   = sub ? ~b : b;
      c0   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bp} + (W+1)'(c0);
      sum  = full[W-1:0];
      ovf  = (a[W-1] == bp[W-1]) && (sum[W-1] != a[W-1]);
      fl   = {5'b00000, (sum == '0), ovf, full[W]};
   endfunction

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      rdwr = 1'b1;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
      rdwr = 1'b0;
      addr = 8'h41;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      rdwr = 1'b0;
      addr = a;
      @(posedge clk);
      @(negedge clk);
      d = dout;
   endtask

   task automatic rd_result(output logic [W-1:0] res);
      logic [7:0] byt;
      for (int i = 0; i < NB; i++) begin
         rd(8'(8'h30 + i), byt);
         res[8*i +: 8] = byt;
      end
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      for (int i = 0; i < NB; i++) wr(8'(i), a[8*i +: 8]);
      for (int i = 0; i < NB; i++) wr(8'(8'h10 + i), b[8*i +: 8]);
      wr(8'h20, {6'b000000, sub, cin});
   endtask

   // Issue START and return the cycle (1 = first cycle after the START edge) of the first DONE
   task automatic start_wait(output int lat);
      lat = -1;
      wr(8'h21, 8'h01);
      for (int n = 1; n <= NS + 4; n++) begin
         @(negedge clk);
         if (done && lat < 0) lat = n;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         output logic [W-1:0] res, output logic [7:0] fl);
      logic [W-1:0] exp_sum;
      logic [7:0]   exp_fl;
      logic [7:0]   st;
      int           lat;
      int           p0;
      load(a, b, cin, sub);
      p0 = done_pulses;
      start_wait(lat);
      check({tag, "_latency"}, 128'(lat), 128'(NS + 1));
      check({tag, "_pulses"}, 128'(done_pulses - p0), 128'd1);
      rd_result(res);
      rd(8'h40, fl);
      rd(8'h41, st);
      model(a, b, cin, sub, exp_sum, exp_fl);
      check({tag, "_result"}, 128'(res), 128'(exp_sum));
      check({tag, "_flags"}, 128'(fl), 128'(exp_fl));
      check({tag, "_status"}, 128'(st), 128'h02);
   endtask

   initial begin
      logic [W-1:0] res;
      logic [W-1:0] res2;
      logic [W-1:0] exp_sum;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [7:0]   fl;
      logic [7:0]   byt;
      logic [7:0]   exp_fl;
      int           p0;
      int           lat;

      rst  = 1'b0;
      rdwr = 1'b0;
      addr = 8'h00;
      din  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_dout", 128'(dout), 128'h00);
      check("reset_done", 128'(done), 128'h0);
      rst = 1'b1;

      rd(8'h41, byt); check("reset_status", 128'(byt), 128'h00);
      rd(8'h40, byt); check("reset_flags", 128'(byt), 128'h00);
      rd(8'h00, byt); check("reset_a0", 128'(byt), 128'h00);
      rd(8'h30, byt); check("reset_res0", 128'(byt), 128'h00);

      // Address map boundaries
      rd(8'(NB), byt);          check("a_out_of_window", 128'(byt), 128'h00);
      rd(8'(8'h30 + NB), byt);  check("res_out_of_window", 128'(byt), 128'h00);
      rd(8'h50, byt);           check("unmapped_50", 128'(byt), 128'hF0);
      rd(8'h22, byt);           check("unmapped_22", 128'(byt), 128'hF0);
      wr(8'(NB), 8'h5A);
      rd(8'(NB), byt);          check("a_oow_write_ignored", 128'(byt), 128'h00);

      // Directed arithmetic cases
      run_op("add_carry", {W{1'b1}}, W'(1), 1'b0, 1'b0, res, fl);
      check("add_carry_const_res", 128'(res), 128'h0);
      check("add_carry_const_fl", 128'(fl), 128'h05);

      run_op("sub", W'(16'h10), W'(16'h11), 1'b0, 1'b1, res, fl);
      check("sub_const_res", 128'(res), 128'(64'hFFFF_FFFF_FFFF_FFFF));
      check("sub_const_fl", 128'(fl), 128'h00);

      run_op("ovf", W'(64'h7FFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0, res, fl);
      check("ovf_const_res", 128'(res), 128'(64'h8000_0000_0000_0000));
      check("ovf_const_fl", 128'(fl), 128'h02);

      // FLAGS keep the previous values while the next operation runs
      load({W{1'b1}}, W'(1), 1'b0, 1'b0);
      wr(8'h21, 8'h01);
      rd(8'h40, byt); check("flags_hold_calc", 128'(byt), 128'h02);
      repeat (NS + 3) @(negedge clk);
      rd(8'h40, byt); check("flags_after_op", 128'(byt), 128'h05);

      // CMD write with bit0 = 0 does nothing
      p0 = done_pulses;
      wr(8'h21, 8'h02);
      repeat (NS + 3) @(negedge clk);
      check("cmd_nostart_pulses", 128'(done_pulses - p0), 128'd0);
      rd(8'h41, byt); check("cmd_nostart_status", 128'(byt), 128'h02);

      // Randomized operations, each followed by a repeated START
      for (int n = 0; n < 24; n++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if (n % 6 == 1) rb = ~ra;
         if (n % 6 == 2) rb = ra;
         run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res, fl);
         if (n % 4 == 0) begin
            p0 = done_pulses;
            start_wait(lat);
            rd_result(res2);
            check($sformatf("rnd%0d_repeat", n), 128'(res2), 128'(res));
            check($sformatf("rnd%0d_repeat_pulses", n), 128'(done_pulses - p0), 128'd1);
         end
      end

      // Writes and START while busy are ignored
      ra = W'(64'h0123_4567_89AB_CD11);
      rb = W'(64'h1111_2222_3333_4444);
      load(ra, rb, 1'b0, 1'b0);
      p0 = done_pulses;
      wr(8'h21, 8'h01);
      wr(8'h00, 8'hAA);
      wr(8'h21, 8'h01);
      repeat (NS + 6) @(negedge clk);
      check("busy_pulses", 128'(done_pulses - p0), 128'd1);
      rd_result(res);
      model(ra, rb, 1'b0, 1'b0, exp_sum, exp_fl);
      check("busy_result", 128'(res), 128'(exp_sum));
      rd(8'h00, byt); check("busy_a0_kept", 128'(byt), 128'h11);

      // Reset during CALC cycle 2 aborts the operation
      load(ra, rb, 1'b1, 1'b0);
      wr(8'h21, 8'h01);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      p0  = done_pulses;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("midreset_dout", 128'(dout), 128'h00);
      rd(8'h41, byt); check("midreset_status", 128'(byt), 128'h00);
      rd_result(res); check("midreset_result", 128'(res), 128'h0);
      rd(8'h00, byt); check("midreset_a0", 128'(byt), 128'h00);
      repeat (NS + 3) @(negedge clk);
      check("midreset_no_done", 128'(done_pulses - p0), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
